// File: rtl/mu_pixel_pack_if.sv
// Pixel-in / packed-word-out handshake bundle for mu_pixel_pack.
// The master side is the packer; the slave side is the pixel source plus FIFO write port.
interface mu_pixel_pack_if #(
   parameter int unsigned PW = 16
);
   localparam int unsigned OW = 2 * PW + 3;

   logic [PW-1:0] in_data;
   logic          in_sof;
   logic          in_eol;
   logic          in_valid;
   logic          in_ready;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      input  in_data, in_sof, in_eol, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

   modport slave (
      output in_data, in_sof, in_eol, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
endinterface

// File: rtl/mu_pixel_pack.sv
// Packs sensor pixel pairs into {half, sof, eol, lane1, lane0} words for the FIFO
// write port, and measures line length / flags SOF arriving mid-word.
module mu_pixel_pack #(
   parameter int unsigned   PW  = 16,
   parameter int unsigned   LW  = 10,
   parameter logic [PW-1:0] PAD = {PW{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   mu_pixel_pack_if.master       bus,
   output logic [LW-1:0]         line_len,
   output logic                  line_len_valid,
   output logic                  err_sof_mid
);
   localparam int unsigned OW      = 2 * PW + 3;
   localparam logic [LW-1:0] CNT_MAX = {LW{1'b1}};
   localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } state_t;

   state_t        state_r;
   state_t        state_next_s;
   logic [PW-1:0] hold_data_r;
   logic          hold_sof_r;
   logic [OW-1:0] out_data_r;
   logic          out_valid_r;
   logic [OW-1:0] word_s;
   logic          load_s;
   logic          flush_s;
   logic          slot_free_s;
   logic          in_ready_s;
   logic          accept_s;
   logic [LW-1:0] cnt_r;
   logic [LW-1:0] cnt_step_s;
   logic [LW-1:0] line_len_r;
   logic          line_len_valid_r;
   logic          err_sof_mid_r;

   // An SOF pixel is refused while a lane0 pixel is held; that cycle flushes instead.
   assign slot_free_s = !out_valid_r || bus.out_ready;
   assign in_ready_s  = slot_free_s && !((state_r == HALF) && bus.in_valid && bus.in_sof);
   assign accept_s    = bus.in_valid && in_ready_s;

   assign bus.in_ready    = in_ready_s;
   assign bus.out_data    = out_data_r;
   assign bus.out_valid   = out_valid_r;
   assign line_len        = line_len_r;
   assign line_len_valid  = line_len_valid_r;
   assign err_sof_mid     = err_sof_mid_r;

   // Next-state and output-word selection for the half-word packer.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      flush_s      = 1'b0;
      word_s       = {OW{1'b0}};
      case (state_r)
         EMPTY: begin
            if (accept_s) begin
               if (bus.in_eol) begin
                  load_s = 1'b1;
                  word_s = {1'b1, bus.in_sof, 1'b1, PAD, bus.in_data};
               end else begin
                  state_next_s = HALF;
               end
            end else begin
               state_next_s = EMPTY;
            end
         end
         HALF: begin
            if (accept_s) begin
               load_s       = 1'b1;
               word_s       = {1'b0, hold_sof_r, bus.in_eol, bus.in_data, hold_data_r};
               state_next_s = EMPTY;
            end else if (bus.in_valid && bus.in_sof && slot_free_s) begin
               load_s       = 1'b1;
               flush_s      = 1'b1;
               word_s       = {1'b1, hold_sof_r, 1'b1, PAD, hold_data_r};
               state_next_s = EMPTY;
            end else begin
               state_next_s = HALF;
            end
         end
         default: begin
            state_next_s = EMPTY;
         end
      endcase
   end

   // Line counter step: SOF restarts at one, otherwise saturating increment.
   always_comb begin
      cnt_step_s = cnt_r;
      if (bus.in_sof) begin
         cnt_step_s = CNT_ONE;
      end else if (cnt_r == CNT_MAX) begin
         cnt_step_s = CNT_MAX;
      end else begin
         cnt_step_s = cnt_r + CNT_ONE;
      end
   end

   // Packer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Hold register, output word register and line statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_data_r      <= {PW{1'b0}};
         hold_sof_r       <= 1'b0;
         out_data_r       <= {OW{1'b0}};
         out_valid_r      <= 1'b0;
         cnt_r            <= {LW{1'b0}};
         line_len_r       <= {LW{1'b0}};
         line_len_valid_r <= 1'b0;
         err_sof_mid_r    <= 1'b0;
      end else begin
         line_len_valid_r <= 1'b0;
         err_sof_mid_r    <= flush_s;
         if (accept_s && (state_r == EMPTY) && !bus.in_eol) begin
            hold_data_r <= bus.in_data;
            hold_sof_r  <= bus.in_sof;
         end
         if (load_s) begin
            out_data_r  <= word_s;
            out_valid_r <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
         if (accept_s) begin
            if (bus.in_eol) begin
               line_len_r       <= cnt_step_s;
               line_len_valid_r <= 1'b1;
               cnt_r            <= {LW{1'b0}};
            end else begin
               cnt_r <= cnt_step_s;
            end
         end
      end
   end
endmodule
